// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants and types for the multi-cycle control unit.
// State codes, opcode/funct values, datapath mux encodings, decoder class.
package mc_ctrl_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_INIT     = 4'd0;
   localparam state_t S_FETCH    = 4'd1;
   localparam state_t S_DECODE   = 4'd2;
   localparam state_t S_EXE_R    = 4'd3;
   localparam state_t S_WB_R     = 4'd4;
   localparam state_t S_EXE_I    = 4'd5;
   localparam state_t S_WB_I     = 4'd6;
   localparam state_t S_MEM_ADDR = 4'd7;
   localparam state_t S_MEM_RD   = 4'd8;
   localparam state_t S_WB_MEM   = 4'd9;
   localparam state_t S_MEM_WR   = 4'd10;
   localparam state_t S_BRANCH   = 4'd11;
   localparam state_t S_JUMP     = 4'd12;
   localparam state_t S_JAL      = 4'd13;
   localparam state_t S_JR       = 4'd14;
   localparam state_t S_TRAP     = 4'd15;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] WD_ALU   = 3'b000;
   localparam logic [2:0] WD_DR    = 3'b001;
   localparam logic [2:0] WD_PC4   = 3'b010;

   localparam logic [1:0] GS_RT    = 2'b00;
   localparam logic [1:0] GS_RD    = 2'b01;
   localparam logic [1:0] GS_R30   = 2'b10;
   localparam logic [1:0] GS_R31   = 2'b11;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_HI   = 2'b10;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_OR   = 2'b10;

   localparam logic [1:0] NPC_PC4  = 2'b00;
   localparam logic [1:0] NPC_BR   = 2'b01;
   localparam logic [1:0] NPC_J    = 2'b10;
   localparam logic [1:0] NPC_JR   = 2'b11;

   localparam logic [1:0] ASEL_ALU = 2'b00;
   localparam logic [1:0] ASEL_B   = 2'b01;

   // One-hot instruction class; exactly one bit set for any opcode/funct.
   typedef struct packed {
      logic addu;
      logic subu;
      logic jr;
      logic ori;
      logic lui;
      logic addi;
      logic load;
      logic store;
      logic beq;
      logic j;
      logic jal;
      logic ill;
   } cls_t;

   // Per-state control word driven onto the datapath.
   typedef struct packed {
      logic       pc_wr;
      logic       ir_wr;
      logic       gpr_wr;
      logic       b_sel;
      logic       dm_wr;
      logic       mem_byte;
      logic [2:0] wd_sel;
      logic [1:0] gpr_sel;
      logic [1:0] ext_op;
      logic [1:0] alu_op;
      logic [1:0] npc_op;
      logic [1:0] alu_sel;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: datapath <-> control bundle.
// master = control unit (drives enables/selects), slave = datapath.
interface mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             zero;
   logic             flow;
   logic             PCWr;
   logic             IRWr;
   logic             GPRWr;
   logic             Bsel;
   logic             DMWr;
   logic             MemByte;
   logic [2:0]       WDsel;
   logic [1:0]       GPRsel;
   logic [1:0]       Extop;
   logic [1:0]       ALUOp;
   logic [1:0]       NPCOp;
   logic [1:0]       ALUsel;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   modport master (
      input  opcode, funct, zero, flow,
      output PCWr, IRWr, GPRWr, Bsel, DMWr, MemByte,
      output WDsel, GPRsel, Extop, ALUOp, NPCOp, ALUsel,
      output illegal, retired
   );

   modport slave (
      output opcode, funct, zero, flow,
      input  PCWr, IRWr, GPRWr, Bsel, DMWr, MemByte,
      input  WDsel, GPRsel, Extop, ALUOp, NPCOp, ALUsel,
      input  illegal, retired
   );
endinterface

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: combinational opcode/funct -> one-hot instruction class.
// Ports: opcode, funct in; cls (one-hot), is_byte, is_store, is_addi out.
module mc_ctrl_dec
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output cls_t       cls,
   output logic       is_byte,
   output logic       is_store,
   output logic       is_addi
);

   always_comb begin
      cls = '0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: cls.addu = 1'b1;
               FN_SUBU: cls.subu = 1'b1;
               FN_JR:   cls.jr   = 1'b1;
               default: cls.ill  = 1'b1;
            endcase
         end
         OP_ORI:       cls.ori   = 1'b1;
         OP_LUI:       cls.lui   = 1'b1;
         OP_ADDI:      cls.addi  = 1'b1;
         OP_LW, OP_LB: cls.load  = 1'b1;
         OP_SW, OP_SB: cls.store = 1'b1;
         OP_BEQ:       cls.beq   = 1'b1;
         OP_J:         cls.j     = 1'b1;
         OP_JAL:       cls.jal   = 1'b1;
         default:      cls.ill   = 1'b1;
      endcase
   end

   assign is_byte  = (opcode == OP_LB) || (opcode == OP_SB);
   assign is_store = cls.store;
   assign is_addi  = cls.addi;

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: Moore multi-cycle control FSM for the MIPS-subset datapath.
// Ports: clk, rst (sync, active-high), bus (mc_ctrl_if.master).
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   mc_ctrl_if.master    bus
);

   state_t           st;
   state_t           nxt;
   logic             ovf_q;
   logic [CNT_W-1:0] ret_q;
   cls_t             cls;
   logic             is_byte;
   logic             is_store;
   logic             is_addi;
   ctrl_t            c;

   mc_ctrl_dec u_dec (
      .opcode   (bus.opcode),
      .funct    (bus.funct),
      .cls      (cls),
      .is_byte  (is_byte),
      .is_store (is_store),
      .is_addi  (is_addi)
   );

   always_comb begin
      nxt = st;
      unique case (st)
         S_INIT:   nxt = S_FETCH;
         S_FETCH:  nxt = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               cls.addu,
               cls.subu:  nxt = S_EXE_R;
               cls.jr:    nxt = S_JR;
               cls.ori,
               cls.lui,
               cls.addi:  nxt = S_EXE_I;
               cls.load,
               cls.store: nxt = S_MEM_ADDR;
               cls.beq:   nxt = S_BRANCH;
               cls.j:     nxt = S_JUMP;
               cls.jal:   nxt = S_JAL;
               default:   nxt = S_TRAP;
            endcase
         end
         S_EXE_R:    nxt = S_WB_R;
         S_EXE_I:    nxt = S_WB_I;
         S_MEM_ADDR: nxt = is_store ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   nxt = S_WB_MEM;
         S_WB_R,
         S_WB_I,
         S_WB_MEM,
         S_MEM_WR,
         S_BRANCH,
         S_JUMP,
         S_JAL,
         S_JR:       nxt = S_FETCH;
         S_TRAP:     nxt = S_TRAP;
         default:    nxt = S_INIT;
      endcase
   end

   // Every return to FETCH except the one out of INIT retires an
   // instruction, including an addi whose write was suppressed.
   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= S_INIT;
         ovf_q <= 1'b0;
         ret_q <= '0;
      end else begin
         st <= nxt;
         if (st == S_EXE_I)
            ovf_q <= bus.flow;
         if (nxt == S_FETCH && st != S_INIT)
            ret_q <= ret_q + CNT_W'(1);
      end
   end

   always_comb begin
      c = '0;
      unique case (st)
         S_FETCH: begin
            c.pc_wr  = 1'b1;
            c.ir_wr  = 1'b1;
            c.npc_op = NPC_PC4;
         end
         S_EXE_R,
         S_WB_R: begin
            c.b_sel  = 1'b0;
            c.alu_op = cls.subu ? ALU_SUB : ALU_ADD;
            if (st == S_WB_R) begin
               c.gpr_wr  = 1'b1;
               c.gpr_sel = GS_RD;
               c.wd_sel  = WD_ALU;
            end
         end
         S_EXE_I,
         S_WB_I: begin
            c.b_sel = 1'b1;
            unique case (1'b1)
               cls.ori: begin
                  c.ext_op = EXT_ZERO;
                  c.alu_op = ALU_OR;
               end
               cls.lui: begin
                  c.ext_op  = EXT_HI;
                  c.alu_sel = ASEL_B;
               end
               default: begin
                  c.ext_op = EXT_SIGN;
                  c.alu_op = ALU_ADD;
               end
            endcase
            // Signed overflow on addi discards the result.
            if (st == S_WB_I) begin
               c.gpr_sel = GS_RT;
               c.wd_sel  = WD_ALU;
               c.gpr_wr  = !(is_addi && ovf_q);
            end
         end
         S_MEM_ADDR: begin
            c.b_sel  = 1'b1;
            c.ext_op = EXT_SIGN;
            c.alu_op = ALU_ADD;
         end
         S_MEM_RD: begin
            c.mem_byte = is_byte;
         end
         S_WB_MEM: begin
            c.gpr_wr   = 1'b1;
            c.gpr_sel  = GS_RT;
            c.wd_sel   = WD_DR;
            c.mem_byte = is_byte;
         end
         S_MEM_WR: begin
            c.dm_wr    = 1'b1;
            c.mem_byte = is_byte;
         end
         S_BRANCH: begin
            c.b_sel  = 1'b0;
            c.alu_op = ALU_SUB;
            c.npc_op = NPC_BR;
            c.pc_wr  = bus.zero;
         end
         S_JUMP: begin
            c.pc_wr  = 1'b1;
            c.npc_op = NPC_J;
         end
         S_JAL: begin
            c.pc_wr   = 1'b1;
            c.npc_op  = NPC_J;
            c.gpr_wr  = 1'b1;
            c.gpr_sel = GS_R31;
            c.wd_sel  = WD_PC4;
         end
         S_JR: begin
            c.pc_wr  = 1'b1;
            c.npc_op = NPC_JR;
         end
         S_TRAP: begin
            c.illegal = 1'b1;
         end
         default: begin
            c = '0;
         end
      endcase
   end

   assign bus.PCWr    = c.pc_wr;
   assign bus.IRWr    = c.ir_wr;
   assign bus.GPRWr   = c.gpr_wr;
   assign bus.Bsel    = c.b_sel;
   assign bus.DMWr    = c.dm_wr;
   assign bus.MemByte = c.mem_byte;
   assign bus.WDsel   = c.wd_sel;
   assign bus.GPRsel  = c.gpr_sel;
   assign bus.Extop   = c.ext_op;
   assign bus.ALUOp   = c.alu_op;
   assign bus.NPCOp   = c.npc_op;
   assign bus.ALUsel  = c.alu_sel;
   assign bus.illegal = c.illegal;
   assign bus.retired = ret_q;

endmodule
